ls86_quad_xor: RTL and testbench
================================

Name: ls86_quad_xor

Overview:
- SN74LS86-compatible quad 2-input exclusive-OR block.
- The four gate outputs are purely combinational and keep the TTL pin names.
- A clocked status wrapper adds registered outputs, change detection and overall parity for synchronous logic in the Kangaroo design.
- Sits on the glue-logic layer between discrete-TTL-equivalent blocks and synchronous control.

Parameters:
- CNT_W, 8, width of each per-gate toggle counter (optional feature only); legal range 2..16.

Ports:
- clk  in  1  system clock; all registers update on its rising edge.
- rst_n  in  1  reset: one clock, synchronous, active-low; sampled on the clk rising edge.
- _1A, _1B  in  1  gate 1 inputs.
- _1Y  out  1  gate 1 output, _1A ^ _1B, combinational.
- _2A, _2B  in  1  gate 2 inputs.
- _2Y  out  1  gate 2 output, _2A ^ _2B, combinational.
- _3A, _3B  in  1  gate 3 inputs.
- _3Y  out  1  gate 3 output, _3A ^ _3B, combinational.
- _4A, _4B  in  1  gate 4 inputs.
- _4Y  out  1  gate 4 output, _4A ^ _4B, combinational.
- y_q  out  4  registered copy of {_4Y,_3Y,_2Y,_1Y}.
- y_chg  out  4  one-cycle pulse per gate when its registered output changed.
- par_q  out  1  registered XOR of all four Y (odd parity of the 8 inputs).

Behaviour:
- _nY combinational:
  - Zero-cycle latency; no dependence on clk or rst_n; valid even while in reset.
  - Truth table per gate: 00->0, 01->1, 10->1, 11->0.
- Registered outputs: at each rising clk edge with rst_n=1:
  - y_q <= current Y vector.
  - y_chg <= y_q_prev ^ Y.
  - par_q <= ^Y.
- Latency: y_q and par_q reflect inputs one cycle after they are applied; y_chg asserts for exactly one cycle, in the same cycle y_q changes.
- Reset values: at a rising clk edge with rst_n=0:
  - y_q=4'b0000, y_chg=4'b0000, par_q=0.
  - Optional-feature counters and saturation flags = 0.
- Reset mid-operation takes effect at the next edge only; there is no asynchronous clear.
- First cycle after reset release:
  - y_chg compares against the reset value 0.
  - Any Y=1 therefore pulses y_chg.
- X/Z on inputs propagate per SystemVerilog XOR semantics; no sanitisation.
- No handshake; inputs are free-running and have no setup requirement beyond normal sync timing.
- Inputs are not synchronised. The integrator supplies clk-domain inputs; async inputs need an external 2-flop synchroniser.

Optional Feature:
- Macro: LS86_TOGGLE_CNT_EN.
- Defined: adds output tog_cnt[4*CNT_W-1:0], with gate n at bits [n*CNT_W-1:(n-1)*CNT_W], and output tog_sat[3:0].
  - Each counter increments by 1 on every cycle its y_chg bit is 1.
  - Counters saturate at all-ones, and the matching tog_sat bit sticks high until reset.
  - Counters and flags clear on synchronous reset.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package ls86_pkg holds:
  - localparam NUM_GATES=4.
  - typedef logic [NUM_GATES-1:0] gate_vec_t.
  - CNT_W default constant.
- Natural sub-module: ls86_xor_gate, one 2-input XOR plus its y_q/y_chg flops (and counter under the macro). Top instantiates it four times and computes par_q.

Test Plan:
- All inputs 0 -> _1Y.._4Y=0; one clk later y_q=0000, par_q=0, y_chg=0000.
- All gates A=0,B=1 -> all Y=1 at zero delay; next edge y_q=1111, y_chg=1111, par_q=0; following edge y_chg=0000.
- All gates A=1,B=0 -> all Y=1; next edge y_q=1111, y_chg=0000.
- All gates A=1,B=1 -> all Y=0; next edge y_q=0000, y_chg=1111.
- Only gate 1 at A=1,B=0, others 0 -> y_q=0001, par_q=1. Then assert rst_n=0 for one edge -> y_q=0000, par_q=0, while _1Y stays 1 throughout.
- With LS86_TOGGLE_CNT_EN and CNT_W=2:
  - Toggle _1A every cycle for 5 cycles -> tog_cnt gate1 reaches 3 and holds, tog_sat[0]=1, other counters 0.
  - Reset -> all counters 0, tog_sat=0000.

Source files
------------

// File: rtl/ls86_pkg.sv
// -----------------------------------------------------------------------------
// ls86_pkg
// Shared definitions for the SN74LS86-compatible quad XOR block.
//   NUM_GATES   : number of 2-input XOR gates in the package (4)
//   gate_vec_t  : one bit per gate, bit 0 = gate 1
//   CNT_W_DEF   : default width of the per-gate toggle counters
//   CNT_W_MIN/MAX: legal range for the toggle counter width
// Optional feature macro: LS86_TOGGLE_CNT_EN (counters live in ls86_xor_gate).
// -----------------------------------------------------------------------------
package ls86_pkg;

    localparam int unsigned NUM_GATES = 4;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned CNT_W_MIN = 2;
    localparam int unsigned CNT_W_MAX = 16;

    typedef logic [NUM_GATES-1:0] gate_vec_t;

endpackage : ls86_pkg

// File: rtl/ls86_xor_gate.sv
// -----------------------------------------------------------------------------
// ls86_xor_gate
// One 2-input XOR gate plus its synchronous status flops.
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   a, b    in   gate inputs
//   y       out  a ^ b, combinational (independent of clk/rst_n)
//   y_q     out  registered y
//   y_chg   out  one-cycle pulse when y_q changes (compares against previous y_q)
//   tog_cnt out  saturating count of y_chg pulses   (LS86_TOGGLE_CNT_EN only)
//   tog_sat out  sticky flag, counter hit all-ones  (LS86_TOGGLE_CNT_EN only)
// Optional feature macro: LS86_TOGGLE_CNT_EN.
// -----------------------------------------------------------------------------
module ls86_xor_gate
    import ls86_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             y,
`ifdef LS86_TOGGLE_CNT_EN
    output logic [CNT_W-1:0] tog_cnt,
    output logic             tog_sat,
`endif
    output logic             y_q,
    output logic             y_chg
);

    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("ls86_xor_gate: CNT_W out of range");
    end

    // X/Z propagate unchanged through the XOR.
    assign y = a ^ b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q   <= 1'b0;
            y_chg <= 1'b0;
        end else begin
            y_q   <= y;
            y_chg <= y_q ^ y;
        end
    end

`ifdef LS86_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = tog_cnt + 1'b1;
    end

    // Counts registered y_chg pulses; the sat flag is raised on the same edge
    // the counter lands on all-ones so both read consistently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tog_cnt <= '0;
            tog_sat <= 1'b0;
        end else if (y_chg && !(&tog_cnt)) begin
            tog_cnt <= cnt_inc;
            if (&cnt_inc) begin
                tog_sat <= 1'b1;
            end
        end
    end
`endif

endmodule : ls86_xor_gate

// File: rtl/ls86_quad_xor.sv
// -----------------------------------------------------------------------------
// ls86_quad_xor
// SN74LS86-compatible quad 2-input XOR with a clocked status wrapper.
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   _nA, _nB       in   gate n inputs (n = 1..4)
//   _nY            out  gate n output, _nA ^ _nB, combinational
//   y_q     [3:0]  out  registered {_4Y,_3Y,_2Y,_1Y}
//   y_chg   [3:0]  out  per-gate one-cycle change pulse, aligned with y_q
//   par_q          out  registered XOR of all four Y
//   tog_cnt [4*CNT_W-1:0] out  per-gate toggle counters (LS86_TOGGLE_CNT_EN)
//   tog_sat [3:0]  out  per-gate sticky saturation flags (LS86_TOGGLE_CNT_EN)
// Optional feature macro: LS86_TOGGLE_CNT_EN.
// Inputs are not synchronised; async sources need an external synchroniser.
// -----------------------------------------------------------------------------
module ls86_quad_xor
    import ls86_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       _1A,
    input  logic                       _1B,
    output logic                       _1Y,
    input  logic                       _2A,
    input  logic                       _2B,
    output logic                       _2Y,
    input  logic                       _3A,
    input  logic                       _3B,
    output logic                       _3Y,
    input  logic                       _4A,
    input  logic                       _4B,
    output logic                       _4Y,
`ifdef LS86_TOGGLE_CNT_EN
    output logic [NUM_GATES*CNT_W-1:0] tog_cnt,
    output logic [NUM_GATES-1:0]       tog_sat,
`endif
    output logic [NUM_GATES-1:0]       y_q,
    output logic [NUM_GATES-1:0]       y_chg,
    output logic                       par_q
);

    gate_vec_t a_vec;
    gate_vec_t b_vec;
    gate_vec_t y_vec;

    assign a_vec = {_4A, _3A, _2A, _1A};
    assign b_vec = {_4B, _3B, _2B, _1B};

    assign _1Y = y_vec[0];
    assign _2Y = y_vec[1];
    assign _3Y = y_vec[2];
    assign _4Y = y_vec[3];

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        ls86_xor_gate #(
            .CNT_W (CNT_W)
        ) u_gate (
            .clk     (clk),
            .rst_n   (rst_n),
            .a       (a_vec[g]),
            .b       (b_vec[g]),
            .y       (y_vec[g]),
`ifdef LS86_TOGGLE_CNT_EN
            .tog_cnt (tog_cnt[g*CNT_W +: CNT_W]),
            .tog_sat (tog_sat[g]),
`endif
            .y_q     (y_q[g]),
            .y_chg   (y_chg[g])
        );
    end

    // Parity is taken from the live Y vector so it lines up with y_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^y_vec;
        end
    end

endmodule : ls86_quad_xor

// File: tb/tb_ls86_quad_xor.sv
module tb_ls86_quad_xor;

    logic clk;
    logic rst_n;
    logic _1A, _1B, _2A, _2B, _3A, _3B, _4A, _4B;
    logic _1Y, _2Y, _3Y, _4Y;
    logic [3:0] y_q;
    logic [3:0] y_chg;
    logic       par_q;
`ifdef LS86_TOGGLE_CNT_EN
    logic [7:0] tog_cnt;
    logic [3:0] tog_sat;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ls86_quad_xor #(
        .CNT_W (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        ._1A     (_1A),
        ._1B     (_1B),
        ._1Y     (_1Y),
        ._2A     (_2A),
        ._2B     (_2B),
        ._2Y     (_2Y),
        ._3A     (_3A),
        ._3B     (_3B),
        ._3Y     (_3Y),
        ._4A     (_4A),
        ._4B     (_4B),
        ._4Y     (_4Y),
`ifdef LS86_TOGGLE_CNT_EN
        .tog_cnt (tog_cnt),
        .tog_sat (tog_sat),
`endif
        .y_q     (y_q),
        .y_chg   (y_chg),
        .par_q   (par_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic a, input logic b);
        _1A = a; _1B = b; _2A = a; _2B = b;
        _3A = a; _3B = b; _4A = a; _4B = b;
    endtask

    // Vectors are bit 0 = gate 1.
    task automatic set_vec(input logic [3:0] a, input logic [3:0] b);
        _1A = a[0]; _1B = b[0]; _2A = a[1]; _2B = b[1];
        _3A = a[2]; _3B = b[2]; _4A = a[3]; _4B = b[3];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] y_comb();
        return {_4Y, _3Y, _2Y, _1Y};
    endfunction

    initial begin
        rst_n = 1'b0;
        set_all(1'b0, 1'b0);
        step();
        check("rst_y_q", y_q, 4'b0000);
        check("rst_y_chg", y_chg, 4'b0000);
        check("rst_par", par_q, 1'b0);
        check("rst_y_comb", y_comb(), 4'b0000);
        rst_n = 1'b1;

        // all inputs 0
        step();
        check("zero_y_q", y_q, 4'b0000);
        check("zero_chg", y_chg, 4'b0000);
        check("zero_par", par_q, 1'b0);

        // A=0, B=1
        set_all(1'b0, 1'b1);
        #1;
        check("01_y_comb", y_comb(), 4'b1111);
        step();
        check("01_y_q", y_q, 4'b1111);
        check("01_chg", y_chg, 4'b1111);
        check("01_par", par_q, 1'b0);
        step();
        check("01_chg_clr", y_chg, 4'b0000);

        // A=1, B=0
        set_all(1'b1, 1'b0);
        #1;
        check("10_y_comb", y_comb(), 4'b1111);
        step();
        check("10_y_q", y_q, 4'b1111);
        check("10_chg", y_chg, 4'b0000);

        // A=1, B=1
        set_all(1'b1, 1'b1);
        #1;
        check("11_y_comb", y_comb(), 4'b0000);
        step();
        check("11_y_q", y_q, 4'b0000);
        check("11_chg", y_chg, 4'b1111);
        check("11_par", par_q, 1'b0);

        // gate 1 only, then mid-operation reset
        set_vec(4'b0001, 4'b0000);
        step();
        check("g1_y_q", y_q, 4'b0001);
        check("g1_par", par_q, 1'b1);
        check("g1_chg", y_chg, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("g1_rst_pre_y_q", y_q, 4'b0001);
        check("g1_rst_1Y_pre", _1Y, 1'b1);
        step();
        check("g1_rst_y_q", y_q, 4'b0000);
        check("g1_rst_par", par_q, 1'b0);
        check("g1_rst_chg", y_chg, 4'b0000);
        check("g1_rst_1Y", _1Y, 1'b1);
        rst_n = 1'b1;
        step();
        check("post_rst_y_q", y_q, 4'b0001);
        check("post_rst_chg", y_chg, 4'b0001);

        // mixed: g1 11, g2 10, g3 01, g4 00 -> Y=0110
        set_vec(4'b0011, 4'b0101);
        #1;
        check("mix1_y_comb", y_comb(), 4'b0110);
        step();
        check("mix1_y_q", y_q, 4'b0110);
        check("mix1_chg", y_chg, 4'b0111);
        check("mix1_par", par_q, 1'b0);

        // g1..g3 = 10, g4 = 00 -> Y=0111
        set_vec(4'b0111, 4'b0000);
        step();
        check("mix2_y_q", y_q, 4'b0111);
        check("mix2_chg", y_chg, 4'b0001);
        check("mix2_par", par_q, 1'b1);

`ifdef LS86_TOGGLE_CNT_EN
        rst_n = 1'b0;
        set_all(1'b0, 1'b0);
        step();
        check("cnt_rst0", tog_cnt, 8'h00);
        check("sat_rst0", tog_sat, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            _1A = ~_1A;
            step();
        end
        check("cnt_sat", tog_cnt, 8'h03);
        check("sat_flag", tog_sat, 4'b0001);
        step();
        step();
        check("cnt_hold", tog_cnt, 8'h03);
        check("sat_hold", tog_sat, 4'b0001);
        rst_n = 1'b0;
        step();
        check("cnt_rst1", tog_cnt, 8'h00);
        check("sat_rst1", tog_sat, 4'b0000);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ls86_quad_xor
